// File: rtl/instr_mem_responder.sv
// Instruction memory responder: accepts PC fetches, returns words after a fixed
// pipeline latency through a credit-protected response FIFO.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [63:0]                    req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_instr,
  output logic [63:0]                    resp_addr,
  output logic                           resp_fault,
  input  logic                           flush,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_data
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int          INF_W     = $clog2(LATENCY + 1) + 1;
  localparam int          CRD_W     = CNT_W + INF_W;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];
  logic [63:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             fault;
  logic             accept;

  logic [LATENCY-1:0] vld_p;
  logic [63:0]        addr_p  [LATENCY];
  logic [31:0]        instr_p [LATENCY];
  logic               fault_p [LATENCY];

  logic [63:0]      fifo_addr  [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic             fifo_fault [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [INF_W-1:0] inflight;
  logic             push;
  logic             pop;

  // Offset wraps unsigned, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset = req_addr - BASE_ADDR;
    idx    = offset[IDX_W+1:2];
    fault  = (offset[1:0] != 2'b00) || (offset[63:IDX_W+2] != '0);
  end

  assign req_ready  = !flush &&
                      ((CRD_W'(inflight) + CRD_W'(fifo_count)) < CRD_W'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign push       = vld_p[LATENCY-1];
  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;

  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Stage p0: array read on the acceptance edge (sees pre-write contents).
  always_ff @(posedge clock) begin
    addr_p[0]  <= req_addr;
    instr_p[0] <= fault ? NOP_INSTR : mem[idx];
    fault_p[0] <= fault;
    for (int i = 1; i < LATENCY; i++) begin
      addr_p[i]  <= addr_p[i-1];
      instr_p[i] <= instr_p[i-1];
      fault_p[i] <= fault_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Response FIFO: entry data is never reset; visibility is gated by fifo_count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= addr_p[LATENCY-1];
      fifo_instr[wr_ptr] <= instr_p[LATENCY-1];
      fifo_fault[wr_ptr] <= fault_p[LATENCY-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      inflight   <= inflight + INF_W'(accept) - INF_W'(push);
    end
  end

  assign resp_instr = resp_valid ? fifo_instr[rd_ptr] : '0;
  assign resp_addr  = resp_valid ? fifo_addr[rd_ptr]  : '0;
  assign resp_fault = resp_valid ? fifo_fault[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a timestamped queue model
// of the fetch responder.
module tb_instr_mem_responder;

  localparam int          DEPTH_WORDS = 256;
  localparam int          LATENCY     = 2;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [63:0] BASE_ADDR   = 64'h0;
  localparam logic [31:0] NOP_WORD    = 32'hD503201F;
  localparam int          IDX_W       = $clog2(DEPTH_WORDS);

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_instr;
  logic [63:0]       resp_addr;
  logic              resp_fault;
  logic              flush;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [31:0]       prog_data;

  always #5 clock = ~clock;

  instr_mem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_addr (resp_addr),
    .resp_fault(resp_fault),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  typedef struct {
    longint unsigned due;
    logic [63:0]     addr;
    logic [31:0]     instr;
    logic            fault;
  } tok_t;

  tok_t            pend[$];
  tok_t            outq[$];
  logic [31:0]     ref_mem [DEPTH_WORDS];
  longint unsigned cyc;
  int              checks;
  int              failures;
  int              acc_cnt;
  bit              armed;
  bit              after_reset;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic step();
    bit          exp_ready;
    tok_t        t;
    logic [63:0] off;
    #1;
    exp_ready = !flush && ((pend.size() + outq.size()) < FIFO_DEPTH);
    if (armed) begin
      check_val("req_ready", req_ready, exp_ready);
      check_val("resp_valid", resp_valid, outq.size() != 0);
      if (outq.size() != 0) begin
        check_val("resp_instr", resp_instr, outq[0].instr);
        check_val("resp_addr", resp_addr, outq[0].addr);
        check_val("resp_fault", resp_fault, outq[0].fault);
      end else if (after_reset) begin
        check_val("rst_instr", resp_instr, 0);
        check_val("rst_addr", resp_addr, 0);
        check_val("rst_fault", resp_fault, 0);
      end
      if (req_valid && req_ready && !reset) acc_cnt++;
    end
    @(posedge clock);
    cyc++;
    if (reset || flush) begin
      pend.delete();
      outq.delete();
    end else begin
      if (outq.size() != 0 && resp_ready) void'(outq.pop_front());
      while (pend.size() != 0 && pend[0].due == cyc) outq.push_back(pend.pop_front());
      if (req_valid && exp_ready) begin
        off     = req_addr - BASE_ADDR;
        t.due   = cyc + LATENCY;
        t.addr  = req_addr;
        t.fault = (off % 4 != 0) || ((off / 4) >= DEPTH_WORDS);
        t.instr = t.fault ? NOP_WORD : ref_mem[off[IDX_W+1:2]];
        pend.push_back(t);
      end
    end
    if (prog_we) ref_mem[prog_addr] = prog_data;
    after_reset = reset;
    if (reset) armed = 1'b1;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    prog_we   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fetch(input logic [63:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    checks = 0; failures = 0; acc_cnt = 0; cyc = 0;
    armed = 1'b0; after_reset = 1'b0;
    @(negedge clock);
    step();
    step();
    reset = 1'b0;

    // Program load: words 0..3 fixed, the rest random.
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      prog_we   = 1'b1;
      prog_addr = IDX_W'(i);
      prog_data = (i < 4) ? 32'(i + 1) * 32'h11111111 : $urandom;
      step();
    end
    idle(2);

    // Back-to-back in-order fetches.
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * i);
      step();
    end
    idle(5);

    // Backpressure: credits limit acceptance to FIFO_DEPTH.
    resp_ready = 1'b0;
    acc_cnt    = 0;
    req_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 64'(4 * (i % 4));
      step();
    end
    req_valid = 1'b0;
    check_val("bp_accepts", acc_cnt, FIFO_DEPTH);
    check_val("bp_ready_low", req_ready, 0);
    resp_ready = 1'b1;
    idle(8);

    // Faulting addresses.
    fetch(64'd6);
    fetch(64'd1024);
    idle(4);

    // Flush squashes in-flight fetches; request in the flush cycle is refused.
    fetch(64'd0);
    fetch(64'd4);
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'd12;
    step();
    flush = 1'b0; req_valid = 1'b0;
    idle(4);
    fetch(64'd8);
    idle(4);

    // Read-before-write on a same-cycle program write.
    prog_we = 1'b1; prog_addr = IDX_W'(1); prog_data = 32'hAAAAAAAA;
    fetch(64'd4);
    prog_we = 1'b0;
    fetch(64'd4);
    idle(4);

    // Reset with two responses buffered and one in flight.
    resp_ready = 1'b0;
    fetch(64'd0);
    fetch(64'd4);
    fetch(64'd8);
    idle(1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    resp_ready = 1'b1;
    idle(3);
    fetch(64'd0);
    fetch(64'd4);
    idle(4);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      prog_we    = ($urandom_range(0, 7) == 0);
      prog_addr  = IDX_W'($urandom_range(0, DEPTH_WORDS - 1));
      prog_data  = $urandom;
      case ($urandom_range(0, 9))
        0:       req_addr = {$urandom, $urandom};
        1:       req_addr = BASE_ADDR + 64'($urandom_range(0, 4 * DEPTH_WORDS + 64));
        default: req_addr = BASE_ADDR + 64'(4 * $urandom_range(0, DEPTH_WORDS - 1));
      endcase
      step();
    end
    reset = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
